// File: rtl/vcve2_obi_pkg.sv
// ----------------------------------------------------------------------------
// vcve2_obi_pkg
// Shared types for the OBI-style req/gnt/rvalid memory responder.
//   obi_req_t : one request beat {we, be, addr, wdata}
//   obi_rsp_t : one response beat {rdata, err}
//   ObiDataW  : data bus width in bits
// ----------------------------------------------------------------------------
package vcve2_obi_pkg;

    localparam int ObiDataW = 32;
    localparam int ObiAddrW = 32;
    localparam int ObiBeW   = ObiDataW / 8;

    typedef struct packed {
        logic                we;
        logic [ObiBeW-1:0]   be;
        logic [ObiAddrW-1:0] addr;
        logic [ObiDataW-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [ObiDataW-1:0] rdata;
        logic                err;
    } obi_rsp_t;

endpackage

// File: rtl/vcve2_obi_rsp_delay.sv
// ----------------------------------------------------------------------------
// vcve2_obi_rsp_delay
// Fixed-latency shift line carrying a valid bit plus one response beat.
// An entry loaded on a clock edge appears at the output Latency-1 edges later,
// so a beat pushed on the grant edge is presented Latency cycles after the
// grant cycle. Asynchronous reset drops everything in flight.
//   clk_i   in   clock
//   rst_i   in   asynchronous, active-high clear
//   valid_i in   push a beat on this edge
//   rsp_i   in   beat to push
//   valid_o out  oldest stage holds a beat
//   rsp_o   out  oldest stage contents (all zero when not valid)
// ----------------------------------------------------------------------------
module vcve2_obi_rsp_delay
    import vcve2_obi_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     valid_i,
    input  obi_rsp_t rsp_i,
    output logic     valid_o,
    output obi_rsp_t rsp_o
);

    logic [Latency-1:0] valid_q;
    obi_rsp_t           rspLine_q [Latency];

    // Shift every cycle with no back-pressure. Empty slots carry an all-zero
    // beat so rdata/err read zero whenever rvalid is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(Latency); i++) begin
                rspLine_q[i] <= '0;
            end
        end else begin
            valid_q[0]   <= valid_i;
            rspLine_q[0] <= valid_i ? rsp_i : '0;
            for (int i = 1; i < int'(Latency); i++) begin
                valid_q[i]   <= valid_q[i-1];
                rspLine_q[i] <= rspLine_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[Latency-1];
    assign rsp_o   = rspLine_q[Latency-1];

endmodule

// File: rtl/vcve2_obi_mem_responder.sv
// ----------------------------------------------------------------------------
// vcve2_obi_mem_responder
// Memory end of an OBI-style req/gnt/rvalid port: word-addressed RAM with a
// fixed response latency, an outstanding-transaction cap, a grant-stall input
// and an error response for addresses outside the mapped window.
//   clk_i        in   clock
//   rst_i        in   asynchronous, active-high reset
//   req_i        in   request valid
//   we_i         in   1=write, 0=read
//   be_i         in   byte enables (writes)
//   addr_i       in   byte address, bits [1:0] ignored
//   wdata_i      in   write data
//   gnt_stall_i  in   forces gnt_o low
//   gnt_o        out  request accepted this cycle
//   rvalid_o     out  single-cycle response strobe
//   rdata_o      out  read data, zero for writes and errors
//   err_o        out  address outside [BaseAddr, BaseAddr+MemWords*4)
// ----------------------------------------------------------------------------
module vcve2_obi_mem_responder
    import vcve2_obi_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ObiBeW-1:0]   be_i,
    input  logic [ObiAddrW-1:0] addr_i,
    input  logic [ObiDataW-1:0] wdata_i,
    input  logic                gnt_stall_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic [ObiDataW-1:0] rdata_o,
    output logic                err_o
);

    localparam int unsigned IdxW     = $clog2(MemWords);
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
    localparam logic [31:0] MemBytes = 32'(MemWords) << 2;
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    obi_req_t            reqBeat;
    obi_rsp_t            rspIn;
    obi_rsp_t            rspOut;
    logic [31:0]         addrOffset;
    logic                inRange;
    logic [IdxW-1:0]     wordIdx;
    logic [CntW-1:0]     outstanding_q;
    logic [CntW-1:0]     outstanding_d;
    logic [ObiDataW-1:0] memArray_q [MemWords];

    assign reqBeat = '{we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};

    // Unsigned 32-bit offset: addresses below BaseAddr wrap to a huge value
    // and therefore fall out of range without a separate lower-bound compare.
    assign addrOffset = reqBeat.addr - BaseAddr;
    assign inRange    = addrOffset < MemBytes;
    assign wordIdx    = addrOffset[IdxW+1:2];

    // A response leaving this cycle frees its slot for a new grant in the
    // same cycle, which is what lets MaxOutstanding >= Latency stream fully.
    assign gnt_o = req_i & ~gnt_stall_i & ~rst_i &
                   ((outstanding_q < CntMax) | rvalid_o);

    // RAM write port. Contents survive reset; gnt_o is already low in reset.
    always_ff @(posedge clk_i) begin
        if (gnt_o && reqBeat.we && inRange) begin
            for (int b = 0; b < ObiBeW; b++) begin
                if (reqBeat.be[b]) begin
                    memArray_q[wordIdx][8*b +: 8] <= reqBeat.wdata[8*b +: 8];
                end
            end
        end
    end

    // Response beat captured on the grant edge: reads take the whole word,
    // writes answer with zero data, out-of-range answers err with zero data.
    always_comb begin
        rspIn = '0;
        if (!inRange) begin
            rspIn.err = 1'b1;
        end else if (!reqBeat.we) begin
            rspIn.rdata = memArray_q[wordIdx];
        end
    end

    // Outstanding count: grant adds one, response removes one, both cancel.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({gnt_o, rvalid_o})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Outstanding counter register; reset forgets everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    vcve2_obi_rsp_delay #(
        .Latency (Latency)
    ) u_rsp_delay (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (gnt_o),
        .rsp_i   (rspIn),
        .valid_o (rvalid_o),
        .rsp_o   (rspOut)
    );

    assign rdata_o = rspOut.rdata;
    assign err_o   = rspOut.err;

    // A response with nothing outstanding would mean the counter underflows.
    OutstandingNoUnderflow: assert property (
        @(posedge clk_i) disable iff (rst_i) !(rvalid_o && (outstanding_q == '0)));

    OutstandingBounded: assert property (
        @(posedge clk_i) disable iff (rst_i) outstanding_q <= CntMax);

endmodule

// File: tb/tb_vcve2_obi_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_vcve2_obi_mem_responder
// Two responder instances: inst0 with Latency=1 at base 0, inst1 with
// Latency=3 at base 0x2000, both MaxOutstanding=2 and 64 words. A reference
// model (word array + queue of pending responses with due cycles) predicts
// every gnt_o and every response; a negedge monitor compares the DUTs to it.
// ----------------------------------------------------------------------------
module tb_vcve2_obi_mem_responder;
    import vcve2_obi_pkg::*;

    localparam int          NumInst  = 2;
    localparam int          MemWords = 64;
    localparam int          MaxOut   = 2;
    localparam logic [31:0] MemBytes = 32'(MemWords * 4);

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } expRsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req      [NumInst];
    logic        we       [NumInst];
    logic [3:0]  be       [NumInst];
    logic [31:0] addr     [NumInst];
    logic [31:0] wdata    [NumInst];
    logic        gntStall [NumInst];
    logic        gnt      [NumInst];
    logic        rvalid   [NumInst];
    logic [31:0] rdata    [NumInst];
    logic        err      [NumInst];

    logic [31:0] modelMem [NumInst][MemWords];
    logic [31:0] lastRdata [NumInst];
    logic        lastErr   [NumInst];
    expRsp_t     expQ0 [$];
    expRsp_t     expQ1 [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          randDone;

    function automatic logic [31:0] baseOf(input int g);
        return (g == 0) ? 32'h0000_0000 : 32'h0000_2000;
    endfunction

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Free-running clock and cycle counter used for response due times.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NumInst; g++) begin : gDut
        vcve2_obi_mem_responder #(
            .MemWords       (MemWords),
            .BaseAddr       (g == 0 ? 32'h0000_0000 : 32'h0000_2000),
            .Latency        (g == 0 ? 1 : 3),
            .MaxOutstanding (MaxOut)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_i       (req[g]),
            .we_i        (we[g]),
            .be_i        (be[g]),
            .addr_i      (addr[g]),
            .wdata_i     (wdata[g]),
            .gnt_stall_i (gntStall[g]),
            .gnt_o       (gnt[g]),
            .rvalid_o    (rvalid[g]),
            .rdata_o     (rdata[g]),
            .err_o       (err[g])
        );
    end

    task automatic checkOutput(input int g, input string name,
                               input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d cyc=%0d got=%h expected=%h", name, g, cyc, got, exp);
        end
    endtask

    // Scoreboard/model step for one instance, run at every negedge.
    task automatic monitorInst(input int g);
        expRsp_t     e;
        int          pending;
        bit          dueNow;
        bit          predGnt;
        logic [31:0] off;
        int          idx;
        pending = (g == 0) ? expQ0.size() : expQ1.size();
        if (rst) begin
            if (g == 0) expQ0.delete(); else expQ1.delete();
            checkOutput(g, "rstGnt",    32'(gnt[g]),    32'h0);
            checkOutput(g, "rstRvalid", 32'(rvalid[g]), 32'h0);
            checkOutput(g, "rstRdata",  rdata[g],       32'h0);
            checkOutput(g, "rstErr",    32'(err[g]),    32'h0);
            return;
        end
        dueNow = 1'b0;
        if (pending > 0) begin
            e = (g == 0) ? expQ0[0] : expQ1[0];
            dueNow = (e.due == cyc);
        end
        checkOutput(g, "rvalid", 32'(rvalid[g]), 32'(dueNow));
        if (rvalid[g]) begin
            lastRdata[g] = rdata[g];
            lastErr[g]   = err[g];
        end
        if (dueNow) begin
            if (g == 0) void'(expQ0.pop_front()); else void'(expQ1.pop_front());
            if (rvalid[g]) begin
                checkOutput(g, "rdata", rdata[g],       e.rdata);
                checkOutput(g, "err",   32'(err[g]),    32'(e.err));
            end
        end
        predGnt = req[g] && !gntStall[g] && ((pending < MaxOut) || dueNow);
        checkOutput(g, "gnt", 32'(gnt[g]), 32'(predGnt));
        if (predGnt) begin
            e.due   = cyc + latOf(g);
            e.rdata = 32'h0;
            e.err   = 1'b0;
            off     = addr[g] - baseOf(g);
            if (off >= MemBytes) begin
                e.err = 1'b1;
            end else begin
                idx = int'(off >> 2);
                if (we[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[g][b]) modelMem[g][idx][8*b +: 8] = wdata[g][8*b +: 8];
                    end
                end else begin
                    e.rdata = modelMem[g][idx];
                end
            end
            if (g == 0) expQ0.push_back(e); else expQ1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NumInst; g++) monitorInst(g);
    end

    // Called just after a posedge; holds the request until granted.
    task automatic applyStimulus(input int g, input logic w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
        bit granted;
        req[g] = 1'b1; we[g] = w; be[g] = b; addr[g] = a; wdata[g] = d;
        granted = 1'b0;
        for (int i = 0; i < 64 && !granted; i++) begin
            @(negedge clk);
            granted = gnt[g];
        end
        if (!granted) checkOutput(g, "gntTimeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        req[g] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // For Latency=1 reads issued just before: the response lands this cycle.
    task automatic checkLast(input int g, input string name,
                             input logic [31:0] expData, input logic expErr);
        @(negedge clk); #1;
        checkOutput(g, {name, "Data"}, lastRdata[g], expData);
        checkOutput(g, {name, "Err"},  32'(lastErr[g]), 32'(expErr));
        @(posedge clk); #1;
    endtask

    task automatic preload(input int g);
        for (int w = 0; w < MemWords; w++) begin
            applyStimulus(g, 1'b1, 4'hF, baseOf(g) + 32'(w * 4), $urandom);
        end
    endtask

    task automatic randomTraffic(input int g, input int n);
        logic [31:0] a;
        int          kind;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      a = baseOf(g) + MemBytes + (32'($urandom_range(0, 15)) << 2);
            else if (kind == 1) a = baseOf(g) - (32'($urandom_range(1, 4)) << 2);
            else                a = baseOf(g) + (32'($urandom_range(0, MemWords - 1)) << 2)
                                    + 32'($urandom_range(0, 3));
            applyStimulus(g, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
        end
    endtask

    initial begin : mainSeq
        logic [7:0] gntPat;
        logic [7:0] rvPat;
        bit         seen;
        rst = 1'b1;
        randDone = 1'b0;
        for (int g = 0; g < NumInst; g++) begin
            req[g] = 1'b0; we[g] = 1'b0; be[g] = 4'h0; addr[g] = 32'h0;
            wdata[g] = 32'h0; gntStall[g] = 1'b0; lastRdata[g] = 32'h0; lastErr[g] = 1'b0;
        end
        idle(3);
        rst = 1'b0;

        fork
            preload(0);
            preload(1);
        join

        $display("[TB] directed read/write on Latency=1 instance");
        applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0);
        checkLast(0, "readBeef", 32'hDEADBEEF, 1'b0);
        applyStimulus(0, 1'b1, 4'b0010, 32'h10, 32'h0000AB00);
        applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0);
        checkLast(0, "readMerged", 32'hDEADABEF, 1'b0);
        applyStimulus(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D);
        applyStimulus(0, 1'b0, 4'h0, MemBytes, 32'h0);
        checkLast(0, "readOOR", 32'h0, 1'b1);
        applyStimulus(0, 1'b1, 4'hF, MemBytes, 32'h12345678);
        applyStimulus(0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkLast(0, "word0Kept", 32'h0BADF00D, 1'b0);
        applyStimulus(0, 1'b0, 4'h0, MemBytes - 32'h4, 32'h0);
        applyStimulus(1, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(6);

        $display("[TB] throttled stream on Latency=3 instance");
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0, 4'h0, 32'h2000 + 32'(i * 4), 32'h0);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    gntPat[i] = gnt[1];
                    rvPat[i]  = rvalid[1];
                end
            end
        join
        checkOutput(1, "gntPattern",    32'(gntPat), 32'h1B);
        checkOutput(1, "rvalidPattern", 32'(rvPat),  32'hD8);
        idle(4);

        $display("[TB] grant stall");
        gntStall[0] = 1'b1;
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'hBAD0BAD0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= gnt[0];
        end
        checkOutput(0, "stallNoGnt", 32'(seen), 32'h0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        gntStall[0] = 1'b0;
        applyStimulus(0, 1'b0, 4'h0, 32'h20, 32'h0);
        gntStall[0] = 1'b1;
        fork
            applyStimulus(0, 1'b1, 4'hF, 32'h24, 32'h5A5AA5A5);
            begin
                repeat (3) @(posedge clk);
                #1 gntStall[0] = 1'b0;
            end
        join
        applyStimulus(0, 1'b0, 4'h0, 32'h24, 32'h0);
        checkLast(0, "stallRelease", 32'h5A5AA5A5, 1'b0);

        $display("[TB] reset with reads in flight");
        applyStimulus(1, 1'b0, 4'h0, 32'h2010, 32'h0);
        applyStimulus(1, 1'b0, 4'h0, 32'h2014, 32'h0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= rvalid[1];
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= rvalid[1];
        end
        checkOutput(1, "rstFlushed", 32'(seen), 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 4'h0, 32'h2010 + 32'(i * 4), 32'h0);

        $display("[TB] randomized traffic");
        fork
            begin
                fork
                    randomTraffic(0, 150);
                    randomTraffic(1, 150);
                join
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk); #1;
                    for (int g = 0; g < NumInst; g++) gntStall[g] = ($urandom_range(0, 3) == 0);
                end
                for (int g = 0; g < NumInst; g++) gntStall[g] = 1'b0;
            end
        join

        for (int i = 0; i < 20 && (expQ0.size() + expQ1.size()) != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        checkOutput(0, "drain", 32'(expQ0.size() + expQ1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
